// File: rtl/ball_collision_pkg.sv
// Shared types, playfield geometry and address helpers for the ball collision probe.
// PROBE_Y_EN (when defined) selects the 4-probe build with top/bottom probes.
package ball_collision_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int ADDR_W  = 19;
    localparam int COORD_W = 11;

`ifdef PROBE_Y_EN
    localparam int N_PROBES = 4;
`else
    localparam int N_PROBES = 2;
`endif

    typedef enum logic [2:0] {IDLE, LATCH, ISSUE, WAIT, DONE} state_e;
    typedef enum logic [1:0] {LEFT, RIGHT, TOP, BOTTOM} probe_e;

    // Y*640 as (Y<<9)+(Y<<7); only meaningful for in-range coordinates
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
        logic [ADDR_W-1:0] yy;
        yy = ADDR_W'(y);
        return (yy << 9) + (yy << 7) + ADDR_W'(x);
    endfunction

    function automatic logic in_range(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y);
        return (x < COORD_W'(H_RES)) && (y < COORD_W'(V_RES));
    endfunction

endpackage

// File: rtl/frame_edge_sync.sv
// Synchronises the asynchronous frame_clk strobe into Clk and emits a 1-cycle pulse on its rising edge.
// Pulse appears SYNC_STAGES cycles after frame_clk rises; no backpressure.
module frame_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic frame_start
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], frame_clk};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign frame_start = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/ball_collision_probe.sv
// Per-frame bitmap probe at the ball edges producing bit_on (and hit_y when PROBE_Y_EN is defined).
// One read outstanding at a time, TIMEOUT-cycle bound per read; a new frame edge aborts a running pass.
module ball_collision_probe
    import ball_collision_pkg::*;
#(
    parameter int TIMEOUT     = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_clk,
    input  logic [9:0]        BallX,
    input  logic [9:0]        BallY,
    input  logic [9:0]        BallS,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic              mem_rd_valid,
    input  logic              mem_rd_data,
    output logic              bit_on,
    output logic              hit_y,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e                state;
    probe_e                idx;
    logic [9:0]            x_r, y_r, s_r;
    logic [N_PROBES-1:0]   hits;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  discard;
    logic                  rd_req;
    logic                  frame_start;

    logic [COORD_W-1:0]    px, py;
    logic                  under;
    logic                  probe_ok;
    logic                  last_probe;
    logic [N_PROBES-1:0]   idx_mask;
    probe_e                next_idx;

    frame_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .frame_start (frame_start)
    );

    always_comb begin
        px    = {1'b0, x_r};
        py    = {1'b0, y_r};
        under = 1'b0;
        case (idx)
            LEFT: begin
                px    = {1'b0, x_r} - {1'b0, s_r};
                under = x_r < s_r;
            end
            RIGHT:  px = {1'b0, x_r} + {1'b0, s_r};
            TOP: begin
                py    = {1'b0, y_r} - {1'b0, s_r};
                under = y_r < s_r;
            end
            BOTTOM: py = {1'b0, y_r} + {1'b0, s_r};
            default: ;
        endcase
    end

    assign probe_ok   = !under && in_range(px, py);
    assign last_probe = (idx == probe_e'(N_PROBES - 1));
    assign idx_mask   = N_PROBES'(1 << idx);
    assign next_idx   = probe_e'(idx + 2'd1);

    // A pending request is withheld in the cycle the pass is being aborted
    assign mem_rd_en = rd_req & ~frame_start;

`ifdef PROBE_Y_EN
    logic hit_y_q;
    assign hit_y = hit_y_q;
`else
    assign hit_y = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            idx         <= LEFT;
            x_r         <= '0;
            y_r         <= '0;
            s_r         <= '0;
            hits        <= '0;
            wait_cnt    <= '0;
            discard     <= 1'b0;
            rd_req      <= 1'b0;
            mem_addr    <= '0;
            bit_on      <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
`ifdef PROBE_Y_EN
            hit_y_q     <= 1'b0;
`endif
        end else begin
            rd_req <= 1'b0;
            if (frame_start) begin
                state <= LATCH;
                busy  <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    LATCH: begin
                        x_r   <= BallX;
                        y_r   <= BallY;
                        s_r   <= BallS;
                        hits  <= '0;
                        idx   <= LEFT;
                        state <= ISSUE;
                    end
                    ISSUE: begin
                        if (probe_ok) begin
                            rd_req   <= 1'b1;
                            mem_addr <= pix_addr(px, py);
                            wait_cnt <= '0;
                            discard  <= 1'b0;
                            state    <= WAIT;
                        end else if (last_probe) begin
                            state <= DONE;
                        end else begin
                            idx <= next_idx;
                        end
                    end
                    WAIT: begin
                        if (mem_rd_valid && !discard) begin
                            if (mem_rd_data) hits <= hits | idx_mask;
                            if (last_probe) state <= DONE;
                            else begin
                                idx   <= next_idx;
                                state <= ISSUE;
                            end
                        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                            // Probe counts as a miss; a late response must not be taken
                            timeout_err <= 1'b1;
                            discard     <= 1'b1;
                            if (last_probe) state <= DONE;
                            else begin
                                idx   <= next_idx;
                                state <= ISSUE;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        bit_on <= |hits[1:0];
`ifdef PROBE_Y_EN
                        hit_y_q <= |hits[3:2];
`endif
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_collision_probe.sv
// Directed bench for ball_collision_probe with a single-outstanding bitmap memory model.
module tb_ball_collision_probe;
    import ball_collision_pkg::*;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              frame_clk = 1'b0;
    logic [9:0]        BallX = '0, BallY = '0, BallS = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic              mem_rd_valid = 1'b0;
    logic              mem_rd_data = 1'b0;
    logic              bit_on, hit_y, busy, timeout_err;

    always #5 Clk = ~Clk;

    ball_collision_probe dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .BallX        (BallX),
        .BallY        (BallY),
        .BallS        (BallS),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .bit_on       (bit_on),
        .hit_y        (hit_y),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [ADDR_W-1:0] addr_q[$];
    int                cyc_q[$];

    logic              mem_respond = 1'b1;
    int                mem_lat     = 1;
    logic [ADDR_W-1:0] set_addr    = '0;
    logic              set_vld     = 1'b0;
    logic              pend        = 1'b0;
    int                cnt         = 0;
    logic              en_s;
    logic [ADDR_W-1:0] a_s, pend_addr;

    // Bitmap memory: one pixel may be set; a new request replaces any pending one
    always @(posedge Clk) begin
        cyc++;
        en_s = mem_rd_en;
        a_s  = mem_addr;
        #1;
        mem_rd_valid = 1'b0;
        mem_rd_data  = 1'b0;
        if (!Reset_n) pend = 1'b0;
        if (en_s) begin
            addr_q.push_back(a_s);
            cyc_q.push_back(cyc);
            pend      = mem_respond;
            cnt       = mem_lat;
            pend_addr = a_s;
        end
        if (pend) begin
            if (cnt <= 1) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = set_vld && (pend_addr == set_addr);
                pend         = 1'b0;
            end else begin
                cnt--;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge Clk);
            n++;
        end
        check("pass_completes", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge Clk);
    endtask

    task automatic start_frame(input logic [9:0] x, input logic [9:0] y, input logic [9:0] s);
        BallX = x;
        BallY = y;
        BallS = s;
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
    endtask

    function automatic logic [31:0] q_at(input int i);
        if (i >= 0 && i < addr_q.size()) return 32'(addr_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        int n;
        repeat (3) @(negedge Clk);
        check("rst_bit_on",      {31'd0, bit_on},      0);
        check("rst_busy",        {31'd0, busy},        0);
        check("rst_mem_rd_en",   {31'd0, mem_rd_en},   0);
        check("rst_timeout_err", {31'd0, timeout_err}, 0);
        check("rst_mem_addr",    32'(mem_addr),        0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Centre ball, right-edge pixel set
        set_addr = 19'd153924; set_vld = 1'b1;
        addr_q.delete(); cyc_q.delete();
        start_frame(10'd320, 10'd240, 10'd4);
        wait_idle();
        check("centre_nreads",   addr_q.size(), 2);
        check("centre_addr0",    q_at(0), 153916);
        check("centre_addr1",    q_at(1), 153924);
        check("centre_bit_on",   {31'd0, bit_on}, 1);
        check("centre_hit_y",    {31'd0, hit_y}, 0);
        check("centre_no_tmo",   {31'd0, timeout_err}, 0);
        check("addr_held",       32'(mem_addr), 153924);

        // Left edge underflows: only the right probe reads
        addr_q.delete(); cyc_q.delete();
        start_frame(10'd2, 10'd240, 10'd4);
        wait_idle();
        check("under_nreads", addr_q.size(), 1);
        check("under_addr0",  q_at(0), 153606);
        check("under_bit_on", {31'd0, bit_on}, 0);

        // Right edge exactly at H_RES is out of range; left pixel set
        set_addr = 19'd7032;
        addr_q.delete(); cyc_q.delete();
        start_frame(10'd636, 10'd10, 10'd4);
        wait_idle();
        check("rbound_nreads", addr_q.size(), 1);
        check("rbound_addr0",  q_at(0), 7032);
        check("rbound_bit_on", {31'd0, bit_on}, 1);

        // Memory never answers: both probes time out
        mem_respond = 1'b0;
        addr_q.delete(); cyc_q.delete();
        start_frame(10'd320, 10'd240, 10'd4);
        wait_idle();
        check("tmo_nreads",   addr_q.size(), 2);
        check("tmo_spacing",  (cyc_q.size() == 2) ? 32'(cyc_q[1] - cyc_q[0]) : 32'hFFFF_FFFF, 16);
        check("tmo_err",      {31'd0, timeout_err}, 1);
        check("tmo_bit_on",   {31'd0, bit_on}, 0);

        // Abort: second frame edge after the first read issues, new X
        mem_respond = 1'b1; mem_lat = 5;
        set_addr = 19'd153696;
        addr_q.delete(); cyc_q.delete();
        start_frame(10'd320, 10'd240, 10'd4);
        n = 0;
        while (addr_q.size() == 0 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check("abort_first_read", {31'd0, addr_q.size() > 0}, 1);
        repeat (2) @(negedge Clk);
        start_frame(10'd100, 10'd240, 10'd4);
        check("abort_busy",      {31'd0, busy}, 1);
        check("abort_bit_on_hold", {31'd0, bit_on}, 0);
        wait_idle();
        check("abort_addr_l",    q_at(addr_q.size() - 2), 153696);
        check("abort_addr_r",    q_at(addr_q.size() - 1), 153704);
        check("abort_bit_on",    {31'd0, bit_on}, 1);
        check("tmo_sticky",      {31'd0, timeout_err}, 1);

        // Async reset while waiting on a read
        mem_respond = 1'b0; mem_lat = 1;
        start_frame(10'd320, 10'd240, 10'd4);
        repeat (4) @(negedge Clk);
        check("pre_reset_busy", {31'd0, busy}, 1);
        Reset_n = 1'b0;
        #1;
        check("arst_bit_on",      {31'd0, bit_on}, 0);
        check("arst_busy",        {31'd0, busy}, 0);
        check("arst_mem_rd_en",   {31'd0, mem_rd_en}, 0);
        check("arst_timeout_err", {31'd0, timeout_err}, 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        mem_respond = 1'b1;
        repeat (2) @(negedge Clk);

`ifdef PROBE_Y_EN
        // Bottom probe out of range, top pixel set
        set_addr = 19'd302180; set_vld = 1'b1;
        addr_q.delete(); cyc_q.delete();
        start_frame(10'd100, 10'd476, 10'd4);
        wait_idle();
        check("y_nreads", addr_q.size(), 3);
        check("y_addr0",  q_at(0), 304736);
        check("y_addr1",  q_at(1), 304744);
        check("y_addr2",  q_at(2), 302180);
        check("y_hit_y",  {31'd0, hit_y}, 1);
        check("y_bit_on", {31'd0, bit_on}, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
